// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer for the 16-bit datapath.
// It latches the fetched instruction word into ir, then drives every datapath
// control strobe from the current state and ir.
// Sequences: FETCH -> DECODE -> EXEC for ALU, shift, LUI, branch and jump;
// FETCH -> DECODE -> MEM for STOR;
// FETCH -> DECODE -> MEM -> WB for LOAD.
// There is no back-pressure: memory returns data in the cycle after the
// address is presented, so every state lasts exactly one cycle.
// fsm_state exposes the current state for observation.
module control_fsm #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   memData,
    output logic [7:0]         instructionOp,
    output logic [7:0]         immediate,
    output logic [REGBITS-1:0] regAddA,
    output logic [REGBITS-1:0] regAddB,
    output logic [3:0]         ALUOp,
    output logic [1:0]         shiftOp,
    output logic [2:0]         busOp,
    output logic               immMUX,
    output logic               regWrite,
    output logic               memWrite,
    output logic               flagWrite,
    output logic [3:0]         flagOp,
    output logic               pcAdd,
    output logic               pcJump,
    output logic               pcBranch,
    output logic               addrSel,
    output logic               illegal,
    output logic [2:0]         fsm_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] ir;
    logic [3:0]       opc;
    logic [3:0]       ext;
    logic             mem_op_fetched;

    assign opc = ir[15:12];
    assign ext = ir[7:4];

    // LOAD (ext 0000) and STOR (ext 0100) under opcode 0100 go through MEM.
    // ir is not loaded until the end of DECODE, so this test reads the bus.
    assign mem_op_fetched = (memData[15:12] == 4'b0100) &&
                            ((memData[7:4] == 4'b0000) || (memData[7:4] == 4'b0100));

    // The instruction fields are plain slices of ir.
    assign instructionOp = {ir[15:12], ir[7:4]};
    assign immediate     = ir[7:0];
    assign regAddA       = ir[REGBITS-1:0];
    assign regAddB       = ir[8 +: REGBITS];
    assign fsm_state     = state;

    // State register, plus the instruction register, which loads only in DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                ir <= memData;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = mem_op_fetched ? S_MEM : S_EXEC;
            S_EXEC:   state_next = S_FETCH;
            S_MEM:    state_next = (ext == 4'b0000) ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Control decode. Outputs depend on state and ir only.
    // Reset forces every output to its idle value so that an aborted
    // instruction cannot leave a strobe behind.
    always_comb begin
        ALUOp     = 4'b0000;
        shiftOp   = 2'b00;
        busOp     = 3'b000;
        immMUX    = 1'b0;
        regWrite  = 1'b0;
        memWrite  = 1'b0;
        flagWrite = 1'b0;
        flagOp    = 4'b0000;
        pcAdd     = 1'b0;
        pcJump    = 1'b0;
        pcBranch  = 1'b0;
        addrSel   = 1'b0;
        illegal   = 1'b0;
        if (!reset) begin
            case (state)
                S_EXEC: begin
                    case (opc)
                        4'h0: begin
                            case (ext)
                                4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hD: begin
                                    ALUOp     = ext;
                                    regWrite  = 1'b1;
                                    flagWrite = 1'b1;
                                    pcAdd     = 1'b1;
                                end
                                4'hB: begin
                                    ALUOp     = ext;
                                    flagWrite = 1'b1;
                                    pcAdd     = 1'b1;
                                end
                                default: begin
                                    illegal = 1'b1;
                                    pcAdd   = 1'b1;
                                end
                            endcase
                        end
                        4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hD: begin
                            immMUX    = 1'b1;
                            ALUOp     = opc;
                            regWrite  = 1'b1;
                            flagWrite = 1'b1;
                            pcAdd     = 1'b1;
                        end
                        4'hB: begin
                            immMUX    = 1'b1;
                            ALUOp     = opc;
                            flagWrite = 1'b1;
                            pcAdd     = 1'b1;
                        end
                        4'h8: begin
                            case (ext)
                                4'h4: begin
                                    busOp    = 3'b001;
                                    regWrite = 1'b1;
                                    pcAdd    = 1'b1;
                                end
                                4'h0, 4'h1: begin
                                    shiftOp  = 2'b01;
                                    immMUX   = 1'b1;
                                    busOp    = 3'b001;
                                    regWrite = 1'b1;
                                    pcAdd    = 1'b1;
                                end
                                4'h6: begin
                                    shiftOp  = 2'b10;
                                    busOp    = 3'b001;
                                    regWrite = 1'b1;
                                    pcAdd    = 1'b1;
                                end
                                default: begin
                                    illegal = 1'b1;
                                    pcAdd   = 1'b1;
                                end
                            endcase
                        end
                        4'hF: begin
                            busOp    = 3'b100;
                            immMUX   = 1'b1;
                            regWrite = 1'b1;
                            pcAdd    = 1'b1;
                        end
                        4'hC: begin
                            immMUX   = 1'b1;
                            flagOp   = ir[11:8];
                            pcBranch = 1'b1;
                        end
                        4'h4: begin
                            case (ext)
                                4'hC: begin
                                    flagOp = ir[11:8];
                                    pcJump = 1'b1;
                                end
                                4'h8: begin
                                    busOp    = 3'b011;
                                    regWrite = 1'b1;
                                    pcJump   = 1'b1;
                                    flagOp   = 4'b1110;
                                end
                                default: begin
                                    illegal = 1'b1;
                                    pcAdd   = 1'b1;
                                end
                            endcase
                        end
                        default: begin
                            illegal = 1'b1;
                            pcAdd   = 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    addrSel = 1'b1;
                    // STOR finishes here; LOAD waits one cycle for the read data.
                    if (ext != 4'b0000) begin
                        memWrite = 1'b1;
                        pcAdd    = 1'b1;
                    end
                end
                S_WB: begin
                    addrSel  = 1'b1;
                    busOp    = 3'b010;
                    regWrite = 1'b1;
                    pcAdd    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm.
// For each instruction word, a reference model built from the instruction
// set's rules predicts the full cycle-by-cycle output trace. Directed words
// run first, then randomized words, with reset injected occasionally in the
// middle of an instruction.
module tb_control_fsm;

    logic        clk;
    logic        reset;
    logic [15:0] memData;
    logic [7:0]  instructionOp;
    logic [7:0]  immediate;
    logic [3:0]  regAddA;
    logic [3:0]  regAddB;
    logic [3:0]  ALUOp;
    logic [1:0]  shiftOp;
    logic [2:0]  busOp;
    logic        immMUX;
    logic        regWrite;
    logic        memWrite;
    logic        flagWrite;
    logic [3:0]  flagOp;
    logic        pcAdd;
    logic        pcJump;
    logic        pcBranch;
    logic        addrSel;
    logic        illegal;
    logic [2:0]  fsm_state;

    typedef struct packed {
        logic [7:0] iop;
        logic [7:0] imm;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] alu;
        logic [1:0] sh;
        logic [2:0] bus;
        logic       immmux;
        logic       rw;
        logic       mw;
        logic       fw;
        logic [3:0] fop;
        logic       pa;
        logic       pj;
        logic       pb;
        logic       as;
        logic       ill;
    } outs_t;

    localparam int OW = $bits(outs_t);
    // Function codes that form write-back ALU instructions (AND OR XOR ADD SUB MOV).
    localparam logic [15:0] ALU_SET = 16'h222E;

    logic [OW-1:0] exp_q[$];
    int            checks;
    int            failures;
    logic [15:0]   prev_ir;
    logic [3:0]    alu_codes[7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hD, 4'hB};
    logic [3:0]    shift_exts[4] = '{4'h4, 4'h0, 4'h1, 4'h6};

    control_fsm #(.WIDTH(16), .REGBITS(4)) dut (
        .clk(clk), .reset(reset), .memData(memData),
        .instructionOp(instructionOp), .immediate(immediate),
        .regAddA(regAddA), .regAddB(regAddB), .ALUOp(ALUOp),
        .shiftOp(shiftOp), .busOp(busOp), .immMUX(immMUX),
        .regWrite(regWrite), .memWrite(memWrite), .flagWrite(flagWrite),
        .flagOp(flagOp), .pcAdd(pcAdd), .pcJump(pcJump), .pcBranch(pcBranch),
        .addrSel(addrSel), .illegal(illegal), .fsm_state(fsm_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its expected value and counts the result.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic outs_t observed();
        outs_t o;
        o.iop = instructionOp; o.imm = immediate; o.ra = regAddA; o.rb = regAddB;
        o.alu = ALUOp; o.sh = shiftOp; o.bus = busOp; o.immmux = immMUX;
        o.rw = regWrite; o.mw = memWrite; o.fw = flagWrite; o.fop = flagOp;
        o.pa = pcAdd; o.pj = pcJump; o.pb = pcBranch; o.as = addrSel;
        o.ill = illegal;
        return o;
    endfunction

    // Idle outputs: instruction fields show the held word; every control is 0.
    function automatic outs_t idle(input logic [15:0] w);
        outs_t o;
        o     = '0;
        o.iop = {w[15:12], w[7:4]};
        o.imm = w[7:0];
        o.ra  = w[3:0];
        o.rb  = w[11:8];
        return o;
    endfunction

    function automatic bit is_load(input logic [15:0] w);
        return (w[15:12] == 4'h4) && (w[7:4] == 4'h0);
    endfunction

    function automatic bit is_stor(input logic [15:0] w);
        return (w[15:12] == 4'h4) && (w[7:4] == 4'h4);
    endfunction

    // Outputs in the one cycle where a non-memory instruction executes.
    function automatic outs_t exec_model(input logic [15:0] w);
        outs_t      o;
        logic [3:0] op;
        logic [3:0] ex;
        o  = idle(w);
        op = w[15:12];
        ex = w[7:4];
        if (op == 4'h0 && (ALU_SET[ex] || ex == 4'hB)) begin
            o.alu = ex; o.rw = (ex != 4'hB); o.fw = 1; o.pa = 1;
        end else if (ALU_SET[op] || op == 4'hB) begin
            o.immmux = 1; o.alu = op; o.rw = (op != 4'hB); o.fw = 1; o.pa = 1;
        end else if (op == 4'h8 && (ex == 4'h4 || ex == 4'h0 || ex == 4'h1 || ex == 4'h6)) begin
            o.sh     = (ex == 4'h6) ? 2'b10 : (ex == 4'h4) ? 2'b00 : 2'b01;
            o.immmux = (ex == 4'h0 || ex == 4'h1);
            o.bus = 3'b001; o.rw = 1; o.pa = 1;
        end else if (op == 4'hF) begin
            o.bus = 3'b100; o.immmux = 1; o.rw = 1; o.pa = 1;
        end else if (op == 4'hC) begin
            o.immmux = 1; o.fop = w[11:8]; o.pb = 1;
        end else if (op == 4'h4 && ex == 4'hC) begin
            o.fop = w[11:8]; o.pj = 1;
        end else if (op == 4'h4 && ex == 4'h8) begin
            o.bus = 3'b011; o.rw = 1; o.pj = 1; o.fop = 4'b1110;
        end else begin
            o.ill = 1; o.pa = 1;
        end
        return o;
    endfunction

    // Pushes the expected trace of instruction w, assuming ir currently holds prev.
    task automatic push_trace(input logic [15:0] w, input logic [15:0] prev);
        outs_t o;
        exp_q.push_back(idle(prev));                  // fetch
        exp_q.push_back(idle(prev));                  // decode
        if (is_load(w)) begin
            o = idle(w); o.as = 1;
            exp_q.push_back(o);
            o.bus = 3'b010; o.rw = 1; o.pa = 1;
            exp_q.push_back(o);
        end else if (is_stor(w)) begin
            o = idle(w); o.as = 1; o.mw = 1; o.pa = 1;
            exp_q.push_back(o);
        end else begin
            exp_q.push_back(exec_model(w));
        end
    endtask

    // Drives one cycle of inputs, then compares the outputs at the falling edge.
    task automatic step(input logic rst, input logic [15:0] md,
                        input logic [OW-1:0] exp, input string tag);
        reset   = rst;
        memData = md;
        @(negedge clk);
        check(tag, 64'(observed()), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction. If abort_at is a valid cycle index, reset is held
    // for `hold` cycles starting at that cycle.
    task automatic run_instr(input logic [15:0] w, input int abort_at, input int hold,
                             input string name);
        int          n;
        logic [15:0] ir_now;
        logic [OW-1:0] e;
        push_trace(w, prev_ir);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            if (k == abort_at) begin
                ir_now = (k >= 2) ? w : prev_ir;
                for (int h = 0; h < hold; h++) begin
                    step(1'b1, (k == 1) ? w : 16'($urandom), 64'(idle(ir_now)),
                         $sformatf("%s rst%0d", name, h));
                    ir_now = 16'h0000;
                end
                exp_q.delete();
                prev_ir = 16'h0000;
                return;
            end
            step(1'b0, (k == 1) ? w : 16'($urandom), e, $sformatf("%s c%0d", name, k));
        end
        prev_ir = w;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] i8;
        a  = 4'($urandom);
        b  = 4'($urandom);
        i8 = 8'($urandom);
        case ($urandom_range(0, 11))
            0:       return {4'h0, b, alu_codes[$urandom_range(0, 6)], a};
            1:       return {alu_codes[$urandom_range(0, 6)], b, i8};
            2:       return {4'h8, b, shift_exts[$urandom_range(0, 3)], a};
            3:       return {4'hF, b, i8};
            4:       return {4'hC, b, i8};
            5:       return {4'h4, b, 4'hC, a};
            6:       return {4'h4, b, 4'h8, a};
            7:       return {4'h4, b, 4'h0, a};
            8:       return {4'h4, b, 4'h4, a};
            default: return 16'($urandom);
        endcase
    endfunction

    // Main stimulus sequence.
    initial begin
        logic [15:0] w;
        int          n_cyc;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        memData  = 16'h0000;
        prev_ir  = 16'h0000;
        @(posedge clk);
        #1;
        step(1'b1, 16'($urandom), 64'(idle(16'h0000)), "reset0");
        step(1'b1, 16'($urandom), 64'(idle(16'h0000)), "reset1");

        run_instr(16'h0351, -1, 0, "add");
        run_instr(16'h52F0, -1, 0, "addi");
        run_instr(16'h4702, -1, 0, "load");
        run_instr(16'h4446, -1, 0, "stor");
        run_instr(16'hC0FE, -1, 0, "bcond");
        run_instr(16'h4E83, -1, 0, "jal");
        run_instr(16'h7000, -1, 0, "illegal");
        run_instr(16'h0351,  2, 2, "add_abort");
        run_instr(16'h0B12, -1, 0, "cmp_after_rst");
        run_instr(16'h4702,  3, 1, "load_abort_wb");
        run_instr(16'h8A06, -1, 0, "shift_imm");

        for (int t = 0; t < 400; t++) begin
            w     = rand_instr();
            n_cyc = is_load(w) ? 4 : 3;
            if ($urandom_range(0, 7) == 0) begin
                run_instr(w, $urandom_range(0, n_cyc - 1), $urandom_range(1, 2), "rnd_abort");
            end else begin
                run_instr(w, -1, 0, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle instruction sequencer that sits directly upstream of the 16-bit datapath.
- Latches the instruction word returned on the memory data bus into an internal instruction register (ir).
- Decodes ir and drives every datapath control strobe: register addresses, ALU/shift/bus selects, write enables and PC-update controls.
- Also provides the memory address-source select (PC vs. regA).

Parameters:
- WIDTH, 16, instruction/data width.
- REGBITS, 4, register-address width.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high
- memData  input  WIDTH  memory read data; instruction word during fetch
- instructionOp  output  8  {ir[15:12], ir[7:4]}, opcode plus extension
- immediate  output  8  ir[7:0]
- regAddA  output  REGBITS  ir[3:0], Rsrc/Raddr
- regAddB  output  REGBITS  ir[11:8], Rdest
- ALUOp  output  4  ALU function code
- shiftOp  output  2  bit0 = immediate shift amount, bit1 = arithmetic
- busOp  output  3  000 ALU, 001 shifter, 010 memory, 011 PC, 100 immediate
- immMUX  output  1  1 = extended immediate as second operand
- regWrite  output  1  register-file write strobe
- memWrite  output  1  memory write strobe
- flagWrite  output  1  ALU flag-register update strobe
- flagOp  output  4  branch/jump condition code, ir[11:8]
- pcAdd  output  1  PC increment strobe
- pcJump  output  1  conditional register-target jump strobe
- pcBranch  output  1  conditional PC-relative branch strobe
- addrSel  output  1  0 = memory address from PC, 1 = from regA
- illegal  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset:
  - Effective on the clock edge where reset = 1.
  - state <= FETCH, ir <= 16'h0000.
  - All strobes (regWrite, memWrite, flagWrite, pcAdd, pcJump, pcBranch, illegal) are 0 while in reset.
  - addrSel = 0.
  - Reset mid-instruction aborts it: no strobe asserts in the reset cycle, and the next cycle is a clean FETCH.
- Outputs are combinational functions of state and ir only; memData is never decoded directly.
- States and transitions:
  - FETCH: addrSel = 0, all strobes 0 -> DECODE.
  - DECODE: ir <= memData, all strobes 0 -> EXEC, or MEM if opcode 0100 with ext 0000/0100.
  - EXEC: performs the decoded instruction; asserts exactly one PC strobe -> FETCH.
  - MEM: addrSel = 1.
    - LOAD -> WB.
    - STOR: memWrite = 1, pcAdd = 1 -> FETCH.
  - WB: addrSel = 1, busOp = 010, regWrite = 1, pcAdd = 1 -> FETCH.
- Decode in EXEC; opc = ir[15:12], ext = ir[7:4]:
  - opc 0000, ext in {0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 1001 SUB, 1101 MOV}:
    - immMUX = 0, ALUOp = ext, busOp = 000, regWrite = 1, flagWrite = 1, pcAdd = 1.
  - opc 0000, ext 1011 (CMP): same as above but regWrite = 0.
  - opc in {0001, 0010, 0011, 0101, 1001, 1101, 1011} (immediate forms):
    - Identical to the R-form above, except immMUX = 1 and ALUOp = opc.
  - opc 1000 (shift):
    - ext 0100: shiftOp = 00, immMUX = 0.
    - ext 000x: shiftOp = 01, immMUX = 1.
    - ext 0110: shiftOp = 10.
    - All shift forms: busOp = 001, regWrite = 1, pcAdd = 1, flagWrite = 0.
  - opc 1111 (LUI): busOp = 100, immMUX = 1, regWrite = 1, pcAdd = 1.
  - opc 1100 (Bcond): immMUX = 1, flagOp = ir[11:8], pcBranch = 1, pcAdd = 0.
  - opc 0100, ext 1100 (Jcond): flagOp = ir[11:8], pcJump = 1.
  - opc 0100, ext 1000 (JAL): busOp = 011, regWrite = 1, pcJump = 1, flagOp = 4'b1110 (always).
  - Any other encoding: illegal = 1, pcAdd = 1, no other strobe (treated as NOP).
- Strobe rules:
  - At most one of pcAdd / pcJump / pcBranch is asserted in any cycle.
  - Every instruction issues exactly one PC strobe in its final cycle.
  - regWrite and memWrite are never asserted together.
- Latency:
  - ALU, shift, LUI, branch, jump: 3 cycles.
  - STOR: 3 cycles.
  - LOAD: 4 cycles.
  - No back-pressure; memory returns data in the cycle following address presentation.
- ir holds its value from DECODE until the next DECODE.
- Default values while not asserted: ALUOp = 0, shiftOp = 0, busOp = 000, immMUX = 0, flagOp = 0.

Test Plan:
- Reset: hold reset 2 cycles in EXEC of ADD -> no regWrite in those cycles; next state FETCH, addrSel = 0, ir = 0.
- ADD: memData 16'h0351 -> EXEC cycle shows regAddB = 3, regAddA = 1, ALUOp = 5, immMUX = 0, regWrite = 1, flagWrite = 1, pcAdd = 1; 3 cycles total.
- ADDI: memData 16'h52F0 -> immMUX = 1, ALUOp = 5, immediate = 8'hF0, regWrite = 1.
- LOAD: 16'h4702 -> MEM cycle addrSel = 1, no strobes; WB cycle busOp = 010, regWrite = 1, pcAdd = 1; 4 cycles.
- STOR: 16'h4446 -> MEM cycle memWrite = 1, pcAdd = 1, regWrite = 0.
- Control flow: Bcond 16'hC0FE -> pcBranch = 1, flagOp = 0, pcAdd = 0. JAL 16'h4E83 -> busOp = 011, regWrite = 1, pcJump = 1. Opcode 16'h7000 -> illegal pulse, pcAdd = 1, no writes.
